// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit -- execute-stage ALU with valid/ready handshakes.
//
// Logic, arithmetic and zero-amount shifts finish one cycle after accept.
// A shift with a non-zero amount moves one bit position per cycle, so it
// occupies the unit for 1+sh cycles before the result is presented.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   flush               synchronous abort of any in-flight operation
//   in_valid/in_ready   upstream handshake for alucode/a/b
//   alucode, a, b       operation select and operands (b[SHW-1:0] = shamt)
//   out_valid/out_ready downstream handshake for result and flags
//   result              registered result
//   zero, sign          result == 0, result MSB
//   carry, overflow     carry-out / NOT borrow, signed overflow
// ---------------------------------------------------------------------------
module alu_exec_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alucode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             sign,
    output logic             carry,
    output logic             overflow
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_COMP = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SHLL = 4'b0100;
    localparam logic [3:0] OP_SHRL = 4'b0101;
    localparam logic [3:0] OP_SHRA = 4'b0110;
    localparam logic [3:0] OP_SUB  = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_work;
    logic [SHW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_sign;
    logic             r_carry;
    logic             r_overflow;

    logic             w_accept;
    logic             w_is_shift;
    logic [SHW-1:0]   w_sh;
    logic [WIDTH-1:0] w_arith_a;
    logic [WIDTH-1:0] w_arith_b;
    logic             w_cin;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_op_result;
    logic             w_op_carry;
    logic             w_op_ovf;
    logic [WIDTH-1:0] w_shifted;
    logic             w_load_result;
    logic             w_start_shift;
    logic [WIDTH-1:0] w_res_d;
    logic             w_carry_d;
    logic             w_ovf_d;

    // One-bit shift step for the iterative shifter; SHRA replicates the MSB.
    function automatic logic [WIDTH-1:0] shift_one(input logic [3:0] op,
                                                   input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        case (op)
            OP_SHLL: r = {v[WIDTH-2:0], 1'b0};
            OP_SHRL: r = {1'b0, v[WIDTH-1:1]};
            OP_SHRA: r = {v[WIDTH-1], v[WIDTH-1:1]};
            default: r = v;
        endcase
        return r;
    endfunction

    assign in_ready   = (r_state == ST_IDLE) && !flush;
    assign w_accept   = in_valid && in_ready;
    assign w_sh       = b[SHW-1:0];
    assign w_is_shift = (alucode == OP_SHLL) || (alucode == OP_SHRL) ||
                        (alucode == OP_SHRA);
    assign w_shifted  = shift_one(r_op, r_work);

    // Shared WIDTH+1 adder: SUB is a + ~b + 1, COMP is 0 + ~b + 1.
    always_comb begin
        w_arith_a = a;
        w_arith_b = b;
        w_cin     = 1'b0;
        case (alucode)
            OP_SUB: begin
                w_arith_b = ~b;
                w_cin     = 1'b1;
            end
            OP_COMP: begin
                w_arith_a = {WIDTH{1'b0}};
                w_arith_b = ~b;
                w_cin     = 1'b1;
            end
            default: begin
                w_arith_b = b;
            end
        endcase
        w_sum = {1'b0, w_arith_a} + {1'b0, w_arith_b} + {{WIDTH{1'b0}}, w_cin};
    end

    // Single-cycle result and flags; zero-amount shifts pass a through.
    always_comb begin
        w_op_result = {WIDTH{1'b0}};
        w_op_carry  = 1'b0;
        w_op_ovf    = 1'b0;
        case (alucode)
            OP_ADD, OP_SUB, OP_COMP: begin
                w_op_result = w_sum[WIDTH-1:0];
                w_op_carry  = w_sum[WIDTH];
                // Overflow when both adder inputs agree in sign and the sum does not.
                w_op_ovf    = (w_arith_a[WIDTH-1] == w_arith_b[WIDTH-1]) &&
                              (w_sum[WIDTH-1] != w_arith_a[WIDTH-1]);
            end
            OP_AND:                  w_op_result = a & b;
            OP_XOR:                  w_op_result = a ^ b;
            OP_SHLL, OP_SHRL, OP_SHRA: w_op_result = a;
            default:                 w_op_result = {WIDTH{1'b0}};
        endcase
    end

    // Next-state logic and result-load decisions; flush overrides everything.
    always_comb begin
        w_next_state  = r_state;
        w_load_result = 1'b0;
        w_start_shift = 1'b0;
        w_res_d       = w_op_result;
        w_carry_d     = w_op_carry;
        w_ovf_d       = w_op_ovf;
        if (flush) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_is_shift && (w_sh != {SHW{1'b0}})) begin
                            w_next_state  = ST_SHIFT;
                            w_start_shift = 1'b1;
                        end else begin
                            w_next_state  = ST_DONE;
                            w_load_result = 1'b1;
                        end
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    // Last step: this cycle's shifted value is the final result.
                    if (r_cnt == SHW'(1)) begin
                        w_next_state  = ST_DONE;
                        w_load_result = 1'b1;
                        w_res_d       = w_shifted;
                        w_carry_d     = 1'b0;
                        w_ovf_d       = 1'b0;
                    end else begin
                        w_next_state = ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        w_next_state = ST_IDLE;
                    end else begin
                        w_next_state = ST_DONE;
                    end
                end
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Shifter working registers and the held result/flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op       <= 4'b0000;
            r_work     <= {WIDTH{1'b0}};
            r_cnt      <= {SHW{1'b0}};
            r_result   <= {WIDTH{1'b0}};
            r_zero     <= 1'b0;
            r_sign     <= 1'b0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_start_shift) begin
                r_op   <= alucode;
                r_work <= a;
                r_cnt  <= w_sh;
            end else if ((r_state == ST_SHIFT) && !flush) begin
                r_work <= w_shifted;
                r_cnt  <= r_cnt - SHW'(1);
            end
            if (w_load_result) begin
                r_result   <= w_res_d;
                r_zero     <= (w_res_d == {WIDTH{1'b0}});
                r_sign     <= w_res_d[WIDTH-1];
                r_carry    <= w_carry_d;
                r_overflow <= w_ovf_d;
            end
        end
    end

    assign out_valid = (r_state == ST_DONE);
    assign result    = r_result;
    assign zero      = r_zero;
    assign sign      = r_sign;
    assign carry     = r_carry;
    assign overflow  = r_overflow;

endmodule
